mash_cic_decimator: RTL and testbench

- Receive-side counterpart of the 3-stage NCSP MASH modulator.
- Consumes the modulator's three carry bitstreams and recombines them through the MASH noise-cancellation network (NCN) into one multi-bit stream y[n].
- Reconstructs the averaged level with a 3rd-order CIC (sinc3) decimator by R = 2^P_LOG2_R.
- Delivers each decimated result over a valid/ready handshake, with a one-entry hold register and a sticky overrun flag.
- Used as a loopback checker for the MASH and as the bitstream demodulator in the test harness.

---
 rtl/mash_pkg.sv | 13 +
 rtl/mash_ncn.sv | 44 ++++
 rtl/mash_cic_decimator.sv | 131 +++++++++++++
 tb/tb_mash_cic_decimator.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mash_pkg.sv
// Shared types and sizing helpers for the MASH bitstream
// demodulator (noise-cancellation network + sinc3 decimator).
package mash_pkg;

  localparam int NCN_WIDTH = 4;

  typedef logic signed [NCN_WIDTH-1:0] ncn_t;

  function automatic int cic_out_width(input int log2_r);
    return 4 + 3 * log2_r;
  endfunction

endpackage

// File: rtl/mash_ncn.sv
// MASH noise-cancellation network: recombines the three carry
// bitstreams into one registered 4-bit signed sample y[n].
module mash_ncn
  import mash_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_c1,
  input  logic i_c2,
  input  logic i_c3,
  output ncn_t o_y
);

  // bit 0 holds the previous enabled sample, bit 1 the one before
  logic [1:0] c1_q, c2_q, c3_q;
  ncn_t       y_q, y_d;

  always_comb begin
    y_d = $signed({3'b000, c1_q[1]})
        + $signed({3'b000, c2_q[0]})
        - $signed({3'b000, c2_q[1]})
        + $signed({3'b000, i_c3})
        - $signed({2'b00, c3_q[0], 1'b0})
        + $signed({3'b000, c3_q[1]});
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      c1_q <= '0;
      c2_q <= '0;
      c3_q <= '0;
      y_q  <= '0;
    end else if (i_en) begin
      c1_q <= {c1_q[0], i_c1};
      c2_q <= {c2_q[0], i_c2};
      c3_q <= {c3_q[0], i_c3};
      y_q  <= y_d;
    end
  end

  assign o_y = y_q;

endmodule

// File: rtl/mash_cic_decimator.sv
// MASH carry-stream demodulator: NCN, 3rd-order CIC decimation by
// 2^P_LOG2_R and a one-entry valid/ready output hold register.
module mash_cic_decimator
  import mash_pkg::*;
#(
  parameter int P_LOG2_R    = 4,
  parameter int P_OUT_WIDTH = cic_out_width(P_LOG2_R)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  input  logic                   i_quantize1,
  input  logic                   i_quantize2,
  input  logic                   i_quantize3,
  output logic [P_OUT_WIDTH-1:0] o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_overrun
);

  localparam int W = P_OUT_WIDTH;

  typedef logic [W-1:0] acc_t;

  ncn_t                y;
  acc_t                y_ext;
  logic [P_LOG2_R-1:0] cnt_q;
  logic                en_q, tick_q, cap_q, s1_q, s2_q;
  acc_t                i1_q, i2_q, i3_q;
  acc_t                d0_q, c1_q, d1_q, c2_q, d2_q;
  acc_t                data_q, data_d;
  logic                valid_q, valid_d;
  logic                ovr_q, ovr_d;

  mash_ncn u_ncn (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_valid),
    .i_c1    (i_quantize1),
    .i_c2    (i_quantize2),
    .i_c3    (i_quantize3),
    .o_y     (y)
  );

  assign y_ext = {{(W-NCN_WIDTH){y[NCN_WIDTH-1]}}, y};

  // Sample counter, integrators and tick alignment.
  // Integrators wrap freely; the comb differences undo the wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      en_q   <= 1'b0;
      tick_q <= 1'b0;
      cap_q  <= 1'b0;
      i1_q   <= '0;
      i2_q   <= '0;
      i3_q   <= '0;
    end else begin
      en_q   <= i_valid;
      tick_q <= i_valid && (cnt_q == '1);
      cap_q  <= tick_q;
      if (i_valid) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (en_q) begin
        i1_q <= i1_q + y_ext;
        i2_q <= i2_q + i1_q;
        i3_q <= i3_q + i2_q;
      end
    end
  end

  // Comb pipeline: one stage per clock, delay taps only move on a tick
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      d0_q <= '0;
      c1_q <= '0;
      d1_q <= '0;
      c2_q <= '0;
      d2_q <= '0;
    end else begin
      s1_q <= cap_q;
      s2_q <= s1_q;
      if (cap_q) begin
        c1_q <= i3_q - d0_q;
        d0_q <= i3_q;
      end
      if (s1_q) begin
        c2_q <= c1_q - d1_q;
        d1_q <= c1_q;
      end
      if (s2_q) begin
        d2_q <= c2_q;
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (s2_q) begin
      data_d  = c2_q - d2_q;
      valid_d = 1'b1;
      if (valid_q && !i_ready) begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_overrun = ovr_q;

endmodule

// File: tb/tb_mash_cic_decimator.sv
// Randomised bench for mash_cic_decimator against a sample-level
// NCN + sinc3 model and a cycle-level output-register model.
module tb_mash_cic_decimator;
  import mash_pkg::*;

  localparam int LR = 4;
  localparam int R  = 1 << LR;
  localparam int W  = cic_out_width(LR);

  logic         clk = 1'b0;
  logic         rst_n;
  logic         vld, q1, q2, q3, rdy;
  logic [W-1:0] data;
  logic         ovalid, ovr;

  always #5 clk = ~clk;

  mash_cic_decimator #(.P_LOG2_R(LR)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (vld),
    .i_quantize1 (q1),
    .i_quantize2 (q2),
    .i_quantize3 (q3),
    .o_data      (data),
    .o_valid     (ovalid),
    .i_ready     (rdy),
    .o_overrun   (ovr)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int           due;
    logic [W-1:0] val;
  } exp_t;

  // Reference model state
  logic [1:0]   h1, h2, h3;
  logic [W-1:0] s1, s2, s3;
  logic [W-1:0] t3 [3];
  int           nsamp;
  exp_t         pend[$];
  int           cyc = 0;
  logic         m_valid, m_ovr, rdy_prev;
  logic [W-1:0] m_data;
  int           out_cnt;
  int           k_en;
  logic         chk_const;
  int           phase_const;

  task automatic model_reset();
    h1 = '0; h2 = '0; h3 = '0;
    s1 = '0; s2 = '0; s3 = '0;
    for (int i = 0; i < 3; i++) t3[i] = '0;
    nsamp    = 0;
    pend.delete();
    m_valid  = 1'b0;
    m_ovr    = 1'b0;
    m_data   = '0;
    rdy_prev = 1'b1;
  endtask

  task automatic model_sample(input logic c1, input logic c2,
                              input logic c3);
    int           y;
    logic [W-1:0] out;
    exp_t         e;
    y = int'(h1[1]) + int'(h2[0]) - int'(h2[1])
      + int'(c3) - 2 * int'(h3[0]) + int'(h3[1]);
    h1 = {h1[0], c1};
    h2 = {h2[0], c2};
    h3 = {h3[0], c3};
    // triple running sum, each stage one sample behind the previous
    s3 = s3 + s2;
    s2 = s2 + s1;
    s1 = s1 + W'(y);
    nsamp++;
    if (nsamp % R == 0) begin
      out = s3 - t3[0] - t3[0] - t3[0]
          + t3[1] + t3[1] + t3[1] - t3[2];
      t3[2] = t3[1];
      t3[1] = t3[0];
      t3[0] = s3;
      e.due = cyc + 5;
      e.val = out;
      pend.push_back(e);
    end
  endtask

  task automatic step(input logic c1, input logic c2, input logic c3,
                      input logic v, input logic r);
    @(negedge clk);
    cyc++;
    q1 = c1; q2 = c2; q3 = c3; vld = v; rdy = r;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      if (m_valid && !rdy_prev) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_data  = pend[0].val;
      void'(pend.pop_front());
    end else if (m_valid && rdy_prev) begin
      m_valid = 1'b0;
    end
    check("o_valid", 32'(ovalid), 32'(m_valid));
    if (m_valid) check("o_data", 32'(data), 32'(m_data));
    check("o_overrun", 32'(ovr), 32'(m_ovr));
    if (ovalid && r) begin
      out_cnt++;
      if (chk_const && out_cnt > 4)
        check("steady", 32'(data), 32'(phase_const));
    end
    rdy_prev = r;
    if (v) model_sample(c1, c2, c3);
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge clk);
    cyc++;
    rst_n = 1'b0;
    vld   = 1'b0;
    #1;
    check({tag, "_valid"}, 32'(ovalid), 32'd0);
    check({tag, "_data"}, 32'(data), 32'd0);
    check({tag, "_ovr"}, 32'(ovr), 32'd0);
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic start_phase(input logic en, input int val);
    chk_const   = en;
    phase_const = val;
    out_cnt     = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    vld = 1'b0; q1 = 1'b0; q2 = 1'b0; q3 = 1'b0; rdy = 1'b1;
    chk_const = 1'b0; phase_const = 0; out_cnt = 0; k_en = 0;
    model_reset();
    #12;
    check("rst_valid", 32'(ovalid), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_ovr", 32'(ovr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // DC input through c1 only
    start_phase(1'b1, R * R * R);
    for (int i = 0; i < 8 * R; i++) step(1, 0, 0, 1, 1);

    // quarter-rate c1 pulses
    start_phase(1'b1, R * R * R / 4);
    for (int i = 0; i < 8 * R; i++) begin
      step(k_en % 4 == 0, 0, 0, 1, 1);
      k_en++;
    end
    start_phase(1'b1, R * R * R / 4);
    for (int i = 0; i < 8 * R; i++) begin
      step(k_en % 4 == 0, 1, 0, 1, 1);
      k_en++;
    end

    // same stream with gaps between samples
    start_phase(1'b1, R * R * R / 4);
    for (int i = 0; i < 16 * R; i++) begin
      step(k_en % 4 == 0, 1, 0, i[0], 1);
      if (i[0]) k_en++;
    end
    start_phase(1'b0, 0);

    // back-pressure across two ticks
    for (int i = 0; i < 2 * R + 10; i++)
      step($urandom_range(1), $urandom_range(1), $urandom_range(1), 1, 0);
    check("ovr_set", 32'(ovr), 32'd1);
    for (int i = 0; i < 40; i++)
      step($urandom_range(1), $urandom_range(1), $urandom_range(1), 1, 1);
    check("ovr_sticky", 32'(ovr), 32'd1);

    // hold a result, then reset mid-frame
    for (int i = 0; i < R + 9; i++)
      step($urandom_range(1), $urandom_range(1), $urandom_range(1), 1, 0);
    check("pre_rst_valid", 32'(ovalid), 32'd1);
    reset_pulse("midrst");
    for (int i = 0; i < 3 * R; i++)
      step($urandom_range(1), $urandom_range(1), $urandom_range(1), 1, 1);

    // long random run, exercises integrator wrap
    for (int i = 0; i < 60000; i++)
      step($urandom_range(1), $urandom_range(1), $urandom_range(1),
           $urandom_range(7) != 0, $urandom_range(3) != 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1);
    check("no_ovr", 32'(ovr), 32'd0);
    check("drained", 32'(pend.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
